reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 139 +++++++++++++
 tb/tb_reset_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release: waits for all clock locks to be stable, then
// frees each reset domain in order; lock loss or soft_rst re-runs it.
module reset_sequencer #(
  parameter int N_LOCK     = 2,
  parameter int N_STAGE    = 3,
  parameter int STABLE_CYC = 1024,
  parameter int STAGE_GAP  = 64,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LOCK-1:0]  lock_in,
  input  logic               soft_rst,
  output logic [N_STAGE-1:0] rst_out,
  output logic               ready,
  output logic [CNT_W-1:0]   loss_cnt,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_STABLE  = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3
  } state_e;

  localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  localparam logic [SW-1:0]      STAB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [GW-1:0]      GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0]      IDX_LAST  = IW'(N_STAGE - 1);
  localparam logic [N_STAGE-1:0] ONE_HOT0  = N_STAGE'(1);

  logic [N_LOCK-1:0]  r_sync1;
  logic [N_LOCK-1:0]  r_sync2;
  state_e             r_state;
  logic [SW-1:0]      r_stab;
  logic [GW-1:0]      r_gap;
  logic [IW-1:0]      r_idx;
  logic [N_STAGE-1:0] r_rst_out;
  logic               r_ready;
  logic [CNT_W-1:0]   r_loss;

  logic w_all_lk;
  logic w_active;

  assign w_all_lk = &r_sync2;
  assign w_active = (r_state == S_RELEASE) || (r_state == S_RUN);

  // lock_in is asynchronous to clk; only r_sync2 is trusted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= lock_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_WAIT;
      r_stab    <= '0;
      r_gap     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_loss    <= '0;
    end else if (soft_rst) begin
      r_state   <= S_WAIT;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
    end else if (w_active && !w_all_lk) begin
      r_state   <= S_WAIT;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      if (r_loss != '1) r_loss <= r_loss + CNT_W'(1);
    end else begin
      case (r_state)
        S_WAIT: begin
          r_rst_out <= '1;
          r_ready   <= 1'b0;
          if (w_all_lk) begin
            r_state <= S_STABLE;
            r_stab  <= '0;
          end
        end
        S_STABLE: begin
          if (!w_all_lk) begin
            r_state <= S_WAIT;
          end else if (r_stab == STAB_LAST) begin
            if (N_STAGE == 1) begin
              r_rst_out <= '0;
              r_ready   <= 1'b1;
              r_state   <= S_RUN;
            end else begin
              r_rst_out <= r_rst_out & ~ONE_HOT0;
              r_state   <= S_RELEASE;
              r_idx     <= IW'(1);
              r_gap     <= '0;
            end
          end else begin
            r_stab <= r_stab + SW'(1);
          end
        end
        S_RELEASE: begin
          if (r_gap == GAP_LAST) begin
            r_rst_out <= r_rst_out & ~(ONE_HOT0 << r_idx);
            r_gap     <= '0;
            r_idx     <= r_idx + IW'(1);
            if (r_idx == IDX_LAST) begin
              r_state <= S_RUN;
              r_ready <= 1'b1;
            end
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        S_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_WAIT;
          r_rst_out <= '1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out  = r_rst_out;
  assign ready    = r_ready;
  assign loss_cnt = r_loss;
  assign state    = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline model of the release schedule
// feeds a scoreboard queue; directed scenarios plus random lock noise.
module tb_reset_sequencer;

  localparam int NL = 2;
  localparam int NS = 3;
  localparam int SC = 16;
  localparam int SG = 4;
  localparam int CW = 4;
  localparam int LMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] lock_in = '0;
  logic          soft_rst = 1'b0;
  logic [NS-1:0] rst_out;
  logic          ready;
  logic [CW-1:0] loss_cnt;
  logic [2:0]    state;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_LOCK(NL), .N_STAGE(NS), .STABLE_CYC(SC),
    .STAGE_GAP(SG), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .lock_in(lock_in),
    .soft_rst(soft_rst), .rst_out(rst_out),
    .ready(ready), .loss_cnt(loss_cnt), .state(state)
  );

  typedef struct packed {
    logic [NS-1:0] ro;
    logic          rdy;
    logic [CW-1:0] lc;
    logic [2:0]    st;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_n = 0;

  // t = edges since STABLE was entered, -1 while waiting
  int          m_t = -1;
  int          m_loss = 0;
  logic [NL-1:0] m_h1 = '0;
  logic [NL-1:0] m_h2 = '0;

  function automatic exp_t predict(int tt, int ll);
    exp_t e;
    e.ro = '1;
    for (int k = 0; k < NS; k++)
      if (tt >= SC + k * SG) e.ro[k] = 1'b0;
    e.rdy = (e.ro == '0);
    e.lc = CW'(ll);
    if (tt < 0)                    e.st = 3'd0;
    else if (tt < SC)              e.st = 3'd1;
    else if (tt < SC + (NS-1)*SG)  e.st = 3'd2;
    else                           e.st = 3'd3;
    return e;
  endfunction

  always @(posedge clk) begin : model
    logic [NL-1:0] lks;
    cyc_n++;
    if (rst) begin
      m_t = -1;
      m_loss = 0;
      m_h1 = '0;
      m_h2 = '0;
    end else begin
      lks = m_h2;
      m_h2 = m_h1;
      m_h1 = lock_in;
      if (soft_rst) begin
        m_t = -1;
      end else if (m_t < 0) begin
        if (&lks) m_t = 0;
      end else if (!(&lks)) begin
        if (m_t >= SC && m_loss < LMAX) m_loss++;
        m_t = -1;
      end else if (m_t < 100000) begin
        m_t++;
      end
    end
    q.push_back(predict(m_t, m_loss));
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      n_vec++;
      if ({rst_out, ready, loss_cnt, state} !== m_e) begin
        n_err++;
        $display("FAIL sb cyc%0d rst_out=%b rdy=%b loss=%0d st=%0d exp rst_out=%b rdy=%b loss=%0d st=%0d",
                 cyc_n, rst_out, ready, loss_cnt, state,
                 m_e.ro, m_e.rdy, m_e.lc, m_e.st);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    lock_in = '0;
    cyc(3);
    chk("reset_rst_out", int'(rst_out), 7);
    chk("reset_loss", int'(loss_cnt), 0);
    chk("reset_state", int'(state), 0);
    rst = 1'b0;
    cyc(2);

    // nominal: locks rise before edge 1
    lock_in = 2'b11;
    cyc(18);
    chk("nom_c18", int'(rst_out), 7);
    cyc(1);
    chk("nom_c19", int'(rst_out), 6);
    cyc(4);
    chk("nom_c23", int'(rst_out), 4);
    chk("nom_c23_rdy", int'(ready), 0);
    cyc(4);
    chk("nom_c27", int'(rst_out), 0);
    chk("nom_c27_rdy", int'(ready), 1);
    chk("nom_loss", int'(loss_cnt), 0);

    // glitch while STABLE
    soft_rst = 1'b1;
    lock_in = 2'b00;
    cyc(1);
    soft_rst = 1'b0;
    cyc(5);
    lock_in = 2'b11;
    cyc(10);
    lock_in[1] = 1'b0;
    cyc(3);
    lock_in[1] = 1'b1;
    cyc(18);
    chk("glitch_c31", int'(rst_out), 7);
    cyc(1);
    chk("glitch_c32", int'(rst_out), 6);
    chk("glitch_loss", int'(loss_cnt), 0);
    cyc(20);
    chk("glitch_run", int'(ready), 1);

    // loss in RUN
    lock_in[0] = 1'b0;
    cyc(3);
    chk("loss_rst_out", int'(rst_out), 7);
    chk("loss_rdy", int'(ready), 0);
    chk("loss_cnt1", int'(loss_cnt), 1);
    lock_in[0] = 1'b1;
    cyc(30);
    chk("loss_rerun", int'(ready), 1);

    // soft_rst on the same edge lk_s drops, during RELEASE
    soft_rst = 1'b1;
    cyc(1);
    soft_rst = 1'b0;
    cyc(18);
    chk("coll_pre_state", int'(state), 2);
    lock_in = 2'b10;
    cyc(2);
    soft_rst = 1'b1;
    cyc(1);
    soft_rst = 1'b0;
    chk("coll_rst_out", int'(rst_out), 7);
    chk("coll_state", int'(state), 0);
    chk("coll_loss", int'(loss_cnt), 1);
    lock_in = 2'b11;
    cyc(30);

    // saturation: 20 loss events from RELEASE/RUN
    for (int i = 0; i < 20; i++) begin
      lock_in = NL'($urandom_range(0, 2));
      cyc(3);
      lock_in = 2'b11;
      cyc(19 + $urandom_range(0, 8));
    end
    chk("sat_loss", int'(loss_cnt), LMAX);

    // async rst between edges, mid-RELEASE
    soft_rst = 1'b1;
    cyc(1);
    soft_rst = 1'b0;
    cyc(20);
    chk("arst_pre_state", int'(state), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_rst_out", int'(rst_out), 7);
    chk("arst_loss", int'(loss_cnt), 0);
    chk("arst_rdy", int'(ready), 0);
    cyc(1);
    rst = 1'b0;
    cyc(30);
    chk("arst_rerun", int'(ready), 1);

    // random lock noise at several drop rates
    for (int blk = 0; blk < 16; blk++) begin
      int p;
      p = (blk % 4 == 0) ? 0 : (blk % 4 == 1) ? 1 : (blk % 4 == 2) ? 3 : 10;
      for (int c = 0; c < 100; c++) begin
        for (int b = 0; b < NL; b++)
          lock_in[b] = ($urandom_range(0, 99) >= p);
        soft_rst = ($urandom_range(0, 199) == 0);
        cyc(1);
      end
    end
    soft_rst = 1'b0;
    lock_in = 2'b11;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
